// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encodings,
// PC step and the layout of a buffered fetch entry {err, pc, data}.
package ifetch_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam int          ENTRY_W = 65;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_unit_fifo.sv
// Synchronous FIFO holding fetched {err, pc, data} entries.
// Flush has priority over push and pop. The head entry is read straight
// from storage, so it is registered and zero after reset.
module ifetch_prefetch_unit_fifo
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [ENTRY_W-1:0]     head
);

  localparam int           PW    = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic               pop_ok;

  assign pop_ok = pop && (count_q != '0);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction prefetch stage: issues single-cycle sequential fetch pulses,
// buffers returned words with their PC and serves them over valid/ready.
// A redirect flushes the buffer and restarts fetch; a response that was
// already in flight when the redirect arrived is discarded.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch/stall/flush counters.
//
// state    | meaning
// ST_ISSUE | decide whether to issue the next fetch (needs a free slot)
// ST_WAIT  | one request outstanding, waiting for mem_ready
// ST_HALT  | a fetch faulted; idle until redirect
module ifetch_prefetch_unit
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_error
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic               discard_q, discard_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      count;

  // Fetch FSM next-state; redirect overrides every state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;
    discard_d  = discard_q;
    push       = 1'b0;
    push_data  = '0;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      if ((state_q == ST_WAIT) && !mem_ready) begin
        discard_d = 1'b1;
        state_d   = ST_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = ST_ISSUE;
      end
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (count < DEPTH_C) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = ST_ISSUE;
            end else if (mem_error) begin
              push      = 1'b1;
              push_data = {1'b1, mem_addr_q, 32'h0};
              state_d   = ST_HALT;
            end else begin
              push       = 1'b1;
              push_data  = {1'b0, mem_addr_q, mem_rdata};
              fetch_pc_d = fetch_pc_q + PC_INC;
              state_d    = ST_ISSUE;
            end
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  // Fetch FSM registers and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      discard_q  <= discard_d;
    end
  end

  // The flush wins over a pop in the redirect cycle.
  assign pop = inst_valid && inst_ready && !redirect_valid;

  ifetch_prefetch_unit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .count    (count),
    .head     (head)
  );

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count != '0);
  assign inst_err   = head[64];
  assign inst_pc    = head[63:32];
  assign inst_data  = head[31:0];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Free-running event counters, wrapping on overflow.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, push};
    perf_stall_d = perf_stall_q + {31'd0, (state_q == ST_ISSUE) && (count == DEPTH_C)};
    perf_flush_d = perf_flush_q + {31'd0, redirect_valid};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: a memory responder, a reference model that
// predicts the output stream from mem responses and redirects, and a monitor
// that pops the expected queue on every handshake.
module tb_ifetch_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_error = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_error     (mem_error)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_req_addr = '0;
  bit          m_out = 0, m_stale = 0, m_halt = 0, prev_req = 0;
  int          n_req = 0, n_push = 0, n_flush = 0;
  logic [31:0] last_req_addr = '0;
  bit          mon_popped = 0;
  int          mem_lat = 2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return a[9:0] == 10'h020;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: mem_ready 'lat' cycles after a pulse (random 1..3 when mem_lat==0).
  initial begin
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      else if (mem_req) begin
        pend  = 1;
        paddr = mem_addr;
        cnt   = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_error = 1'b0;
      mem_rdata = $urandom;
      if (pend && rst_n) begin
        cnt--;
        if (cnt == 0) begin
          pend      = 0;
          mem_ready = 1'b1;
          mem_error = mem_fault(paddr);
          mem_rdata = mem_word(paddr);
        end
      end
    end
  end

  // Monitor: expected queue mirrors FIFO contents; compare on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mon_popped = 0;
      if (rst_n) begin
        check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          mon_popped = 1;
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
          check("inst_err", 32'(inst_err), 32'(e.err));
        end
      end
    end
  end

  // Reference model: validates requests and predicts pushes from responses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        m_fetch_pc = RESET_PC;
        m_out = 0; m_stale = 0; m_halt = 0; prev_req = 0;
        n_push = 0; n_flush = 0;
      end else begin
        if (mem_req) begin
          n_req++;
          last_req_addr = mem_addr;
          check("req_addr", mem_addr, m_fetch_pc);
          check("req_one_outstanding", 32'(m_out), 32'd0);
          check("req_while_halted", 32'(m_halt), 32'd0);
          check("req_credit", 32'(exp_q.size() + int'(mon_popped) < DEPTH), 32'd1);
          check("req_pulse_width", 32'(prev_req), 32'd0);
          m_out = 1;
          m_req_addr = mem_addr;
        end
        if (redirect_valid) begin
          n_flush++;
          exp_q.delete();
          m_fetch_pc = redirect_pc & ~32'h3;
          m_halt = 0;
          if (m_out) begin
            if (mem_ready) m_out = 0;
            else m_stale = 1;
          end
        end else if (mem_ready && m_out) begin
          m_out = 0;
          if (m_stale) m_stale = 0;
          else if (mem_error) begin
            exp_q.push_back('{1'b1, m_req_addr, 32'h0});
            m_halt = 1;
            n_push++;
          end else begin
            exp_q.push_back('{1'b0, m_req_addr, mem_rdata});
            m_fetch_pc = m_fetch_pc + 32'd4;
            n_push++;
          end
        end
        prev_req = mem_req;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name, output bit found, output logic [31:0] addr);
    found = 0;
    addr  = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1;
        addr  = mem_addr;
      end
    end
    if (!found) check(name, 32'd0, 32'd1);
  endtask

  // Stimulus
  initial begin
    bit          found;
    logic [31:0] a;
    int          base, dly;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_err", 32'(inst_err), 32'd0);
    step();
    rst_n = 1'b1;

    // Sequential fetch from 0 until the fault at 0x20, then halt.
    mem_lat = 2;
    inst_ready = 1'b1;
    for (int i = 0; i < 150 && !m_halt; i++) step();
    repeat (15) step();
    check("req_count_to_fault", n_req, 32'd9);
    check("halt_last_addr", last_req_addr, 32'h20);

    // Redirect out of HALT resumes fetching.
    do_redirect(32'h40);
    repeat (30) step();
    check("resume_after_fault", 32'(n_req > 9), 32'd1);

    // Redirect while waiting for 0x8: response dropped, restart at 0x100.
    do_redirect(32'h0);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h8) found = 1;
    end
    check("saw_req_0x8", 32'(found), 32'd1);
    step();
    do_redirect(32'h103);
    wait_pulse("pulse_after_redirect", found, a);
    if (found) check("redirect_req_addr", a, 32'h100);
    repeat (20) step();

    // Redirect coinciding with mem_ready: word dropped, restart at redirect_pc.
    wait_pulse("pulse_before_same_cycle", found, a);
    @(posedge clk);
    step();
    do_redirect(32'h200);
    wait_pulse("pulse_after_same_cycle", found, a);
    if (found) check("same_cycle_req_addr", a, 32'h200);
    repeat (20) step();

    // Consumer stall: exactly DEPTH fetches, then release.
    inst_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    base = n_req;
    rst_n = 1'b1;
    repeat (40) step();
    check("stall_req_count", n_req - base, DEPTH);
    check("stall_last_addr", last_req_addr, 32'hC);
    inst_ready = 1'b1;
    found = 0;
    dly = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1;
        dly = k;
        a = mem_addr;
      end
    end
    check("release_pulse_seen", 32'(found), 32'd1);
    check("release_pulse_delay_le2", 32'(dly <= 2), 32'd1);
    check("release_pulse_addr", a, 32'h10);
    step();

    // Randomized traffic: random latency, consumer stalls, redirects incl. wrap.
    mem_lat = 0;
    for (int i = 0; i < 900; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3));
        else redirect_pc = 32'($urandom_range(0, 1023));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (20) step();

`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 32'(n_push));
    check("perf_flush_cnt", perf_flush_cnt, 32'(n_flush));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
